// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and scan-code helpers
// for the PS/2 letter front end.
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_BREAK,
    D_EXT,
    D_EXT_BREAK
  } dec_state_e;

  function automatic logic is_letter(input logic [7:0] c);
    return c inside {
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
      8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
      8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
      8'h35, 8'h1A
    };
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, 11-bit frame FSM,
// odd-parity check and inter-edge watchdog.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    clk_s;
  logic [1:0]    dat_s;
  rx_state_e     st;
  logic [2:0]    cnt;
  logic [7:0]    sh;
  logic          par_ok;
  logic [WW-1:0] wd;
  logic          fall;
  logic          bit_in;
  logic          timeout;

  // clk_s[2] is the previous synchronized level, used for edge detect
  assign fall    = clk_s[2] & ~clk_s[1];
  assign bit_in  = dat_s[1];
  assign timeout = (st != RX_IDLE) && !fall &&
                   (wd == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      clk_s      <= '0;
      dat_s      <= '0;
      st         <= RX_IDLE;
      cnt        <= '0;
      sh         <= '0;
      par_ok     <= 1'b0;
      wd         <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      clk_s      <= {clk_s[1:0], ps2_clk};
      dat_s      <= {dat_s[0], ps2_data};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (fall || st == RX_IDLE) wd <= '0;
      else                       wd <= wd + 1'b1;

      if (timeout) begin
        st        <= RX_IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        unique case (st)
          RX_IDLE: begin
            if (!bit_in) begin
              st  <= RX_DATA;
              cnt <= '0;
              sh  <= '0;
            end
          end
          RX_DATA: begin
            sh  <= {bit_in, sh[7:1]};
            cnt <= cnt + 1'b1;
            if (cnt == 3'd7) st <= RX_PARITY;
          end
          RX_PARITY: begin
            par_ok <= (^sh) ^ bit_in;
            st     <= RX_STOP;
          end
          RX_STOP: begin
            if (bit_in && par_ok) begin
              byte_valid <= 1'b1;
              rx_byte    <= sh;
            end else begin
              frame_err <= 1'b1;
            end
            st <= RX_IDLE;
          end
          default: st <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_letter_ctrl.sv
// Make/break decoder, single-entry key slot toward the core
// and the two seven-segment display latches.
module ps2_letter_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  input  logic       key_ready,
  input  logic       enc_valid,
  input  logic [7:0] enc_code,
  output logic [7:0] disp_in_code,
  output logic       disp_in_en,
  output logic [7:0] disp_out_code,
  output logic       disp_out_en,
  output logic       frame_err,
  output logic       overrun
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  dec_state_e dst;
  logic [7:0] held;
  logic       retire;
  logic       load;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock     (clock),
    .reset_L   (reset_L),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  // held suppresses typematic repeats until the matching break
  always_comb begin
    retire = key_valid && key_ready;
    load   = byte_valid && (dst == D_IDLE) &&
             is_letter(rx_byte) && (rx_byte != held);
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      dst           <= D_IDLE;
      held          <= '0;
      key_valid     <= 1'b0;
      key_code      <= '0;
      overrun       <= 1'b0;
      disp_in_code  <= '0;
      disp_in_en    <= 1'b0;
      disp_out_code <= '0;
      disp_out_en   <= 1'b0;
    end else begin
      overrun <= 1'b0;

      if (retire) key_valid <= 1'b0;
      if (load) begin
        if (!key_valid || retire) begin
          key_code  <= rx_byte;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (enc_valid && is_letter(enc_code)) begin
        disp_out_code <= enc_code;
        disp_out_en   <= 1'b1;
      end
      // a fresh key press blanks the lamp until the core answers
      if (retire) begin
        disp_in_code <= key_code;
        disp_in_en   <= 1'b1;
        disp_out_en  <= 1'b0;
      end

      if (byte_valid) begin
        unique case (dst)
          D_IDLE: begin
            unique case (1'b1)
              rx_byte == BREAK_CODE: dst <= D_BREAK;
              rx_byte == EXT_CODE:   dst <= D_EXT;
              default: if (load) held <= rx_byte;
            endcase
          end
          D_BREAK: begin
            if (rx_byte == held) held <= '0;
            dst <= D_IDLE;
          end
          D_EXT: begin
            dst <= (rx_byte == BREAK_CODE) ? D_EXT_BREAK : D_IDLE;
          end
          D_EXT_BREAK: dst <= D_IDLE;
          default:     dst <= D_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_letter_ctrl.md
# ps2_letter_ctrl

Front-end controller between the PS/2 keyboard pins and the Enigma core. Receives raw PS/2 frames, decodes make/break/extended sequences, and issues one letter key-press per physical press to the core over a valid/ready handshake. Latches the pressed letter and the core's encrypted letter as the two scan codes that drive the seven-segment scan-code decoders, with blanking control.

## Interface
Parameters:
- TIMEOUT_CYCLES, 50000: clocks without a PS/2 falling edge before a partial frame is aborted.

Ports:
- clock  in  1  system clock; all state on rising edge
- reset_L  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clock
- ps2_data  in  1  raw PS/2 data, asynchronous to clock
- key_valid  out  1  letter make code pending for the core
- key_code  out  8  scan code of the pending letter; stable while key_valid
- key_ready  in  1  core accepts key_code this cycle
- enc_valid  in  1  core returns an encrypted letter this cycle
- enc_code  in  8  scan code of the encrypted letter
- disp_in_code  out  8  scan code shown on the "pressed" digit
- disp_in_en  out  1  1 = show pressed digit, 0 = blank
- disp_out_code  out  8  scan code shown on the "lamp" digit
- disp_out_en  out  1  1 = show lamp digit, 0 = blank
- frame_err  out  1  one-cycle pulse: parity/start/stop error or timeout
- overrun  out  1  one-cycle pulse: letter make dropped because the slot was full

## Operation
- Reset: every output and register 0; receiver in RX_IDLE, decoder in D_IDLE, held register cleared.
- Receiver: 2-flop synchronizers on ps2_clk/ps2_data; falling edge of synchronized ps2_clk samples data. States RX_IDLE (await start bit 0), RX_DATA (8 bits, LSB first), RX_PARITY (odd parity over data+parity), RX_STOP (must be 1). Good frame -> one-cycle byte_valid with byte. Start bit 1 at edge: stay idle, no error. Bad parity or stop: frame_err, byte discarded, RX_IDLE.
- Watchdog: counter cleared on every sampled edge and in RX_IDLE; reaching TIMEOUT_CYCLES outside RX_IDLE -> frame_err, RX_IDLE.
- Decoder states: D_IDLE, D_BREAK (after F0), D_EXT (after E0), D_EXT_BREAK (after E0 F0). F0 from D_IDLE -> D_BREAK; E0 from D_IDLE -> D_EXT; F0 from D_EXT -> D_EXT_BREAK; any other byte in D_EXT/D_EXT_BREAK is ignored and returns to D_IDLE.
- Make in D_IDLE: non-letter ignored. Letter equal to held ignored (typematic repeat). Otherwise held <= code; if slot empty (or retiring this cycle) load key_code, key_valid=1; else overrun pulse, slot unchanged.
- Break in D_BREAK: if code == held, held cleared; return to D_IDLE regardless.
- Handshake: key_valid holds until key_valid && key_ready. Retire and new load in the same cycle: key_valid stays 1 with the new code.
- Display: on retire, disp_in_code <= key_code, disp_in_en <= 1, disp_out_en <= 0. On enc_valid with a letter enc_code, disp_out_code <= enc_code, disp_out_en <= 1; non-letter enc_code ignored. Retire and enc_valid in the same cycle: retire wins for disp_out_en (blank).
- Letter set: the 26 scan codes 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.

## Timing
- Synchronizer latency 2 cycles; edge detect 1 further cycle.
- byte_valid is registered in the cycle after the stop-bit edge is detected; key_valid rises the next cycle.
- Display registers update the cycle after retire or enc_valid.
- frame_err and overrun are registered, high exactly one cycle.
- Reset asserted mid-frame or mid-handshake: immediate clear; the partial frame is lost and the pending key dropped.

## Structure
- Package ps2_pkg: BREAK_CODE 8'hF0, EXT_CODE 8'hE0, rx/decoder state enums, function is_letter(scan code).
- Sub-module ps2_rx: synchronizers, receiver FSM, parity, watchdog; outputs byte_valid, byte, frame_err.
- Top: decoder FSM, held register, output slot, display registers.

## Test plan
- Frame 1C (A), then F0 1C, key_ready high -> one key_valid with key_code 1C; disp_in_code 1C, disp_in_en 1, disp_out_en 0; then enc_valid with 2B -> disp_out_code 2B, disp_out_en 1.
- Typematic: 1C 1C 1C F0 1C 1C with key_ready high -> exactly two key-presses, both code 1C.
- key_ready low, frames 1C then 32 -> key_code stays 1C, overrun pulses once; raise key_ready -> retire 1C, no 32.
- Frame with bad parity for 24 -> frame_err pulse, no key_valid; frame stalled after 4 bits for TIMEOUT_CYCLES -> frame_err, next good 24 frame accepted.
- E0 75 and E0 F0 75, then 5A, then 44 -> no key_valid for the first three; 44 accepted.
- reset_L low mid-frame and with key_valid pending -> all outputs 0 asynchronously; after release, 3A frame produces key_code 3A.
